// File: rtl/note_judge.sv
// Rhythm-game timing judge: one hit window per lane, key-press edge judging,
// and a fixed-priority serialiser onto a single judgement stream.

module note_judge_lane #(
    parameter int GOOD_WIN    = 8,
    parameter int PERFECT_WIN = 2,
    parameter int STRAY_MISS  = 1,
    parameter int CW          = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       note,
    input  logic       key,
    input  logic       pop,
    output logic       active,
    output logic [1:0] pend,
    output logic       drop
);
    typedef enum logic {IDLE = 1'b0, OPEN = 1'b1} state_t;

    localparam logic [1:0] CODE_MISS    = 2'b01;
    localparam logic [1:0] CODE_GOOD    = 2'b10;
    localparam logic [1:0] CODE_PERFECT = 2'b11;
    localparam logic [CW-1:0] MAXC = CW'(2 * GOOD_WIN);
    localparam logic [CW-1:0] P_LO = CW'(GOOD_WIN - PERFECT_WIN);
    localparam logic [CW-1:0] P_HI = CW'(GOOD_WIN + PERFECT_WIN);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          key_q, key_d;
    logic [1:0]    pend_q, pend_d;
    logic [1:0]    post;
    logic          press;
    logic          closing;

    always_comb begin
        key_d   = key;
        press   = enable & key & ~key_q;
        closing = (cnt_q == MAXC);
        post    = 2'b00;
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pop ? 2'b00 : pend_q;
        drop    = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            pend_d  = 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (press && (STRAY_MISS != 0))
                        post = CODE_MISS;
                end
                OPEN: begin
                    // A press always judges the old note, even if a new note arrives.
                    if (press)
                        post = (cnt_q >= P_LO && cnt_q <= P_HI) ? CODE_PERFECT : CODE_GOOD;
                    else if (closing || note)
                        post = CODE_MISS;
                    if (press || closing || note) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
            if (note) begin
                state_d = OPEN;
                cnt_d   = '0;
            end
            if (post != 2'b00) begin
                drop   = (pend_q != 2'b00) && !pop;
                pend_d = post;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            key_q   <= 1'b0;
            pend_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            pend_q  <= pend_d;
        end
    end

    assign active = (state_q == OPEN);
    assign pend   = pend_q;
endmodule

module note_judge #(
    parameter  int NUM_LANES   = 4,
    parameter  int GOOD_WIN    = 8,
    parameter  int PERFECT_WIN = 2,
    parameter  int STRAY_MISS  = 1,
    localparam int LW          = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [NUM_LANES-1:0] note_in,
    input  logic [NUM_LANES-1:0] key_in,
    output logic [1:0]           score_updater_selector,
    output logic                 judge_valid,
    output logic [LW-1:0]        judge_lane,
    output logic [NUM_LANES-1:0] lane_active,
    output logic                 drop_sticky
);
    localparam int CW = $clog2(2 * GOOD_WIN + 1);

    logic [NUM_LANES-1:0][1:0] pend;
    logic [NUM_LANES-1:0]      pop;
    logic [NUM_LANES-1:0]      drop;

    logic [1:0]    sel_q, sel_d;
    logic          valid_q, valid_d;
    logic [LW-1:0] lane_q, lane_d;
    logic          drop_sticky_q, drop_sticky_d;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        note_judge_lane #(
            .GOOD_WIN   (GOOD_WIN),
            .PERFECT_WIN(PERFECT_WIN),
            .STRAY_MISS (STRAY_MISS),
            .CW         (CW)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .enable(enable),
            .note  (note_in[i]),
            .key   (key_in[i]),
            .pop   (pop[i]),
            .active(lane_active[i]),
            .pend  (pend[i]),
            .drop  (drop[i])
        );
    end

    // Fixed priority: lowest-index pending lane wins each cycle.
    always_comb begin
        pop     = '0;
        sel_d   = 2'b00;
        valid_d = 1'b0;
        lane_d  = '0;
        if (enable) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (!valid_d && pend[i] != 2'b00) begin
                    valid_d = 1'b1;
                    pop[i]  = 1'b1;
                    sel_d   = pend[i];
                    lane_d  = LW'(i);
                end
            end
        end
        drop_sticky_d = drop_sticky_q | (|drop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q         <= 2'b00;
            valid_q       <= 1'b0;
            lane_q        <= '0;
            drop_sticky_q <= 1'b0;
        end else begin
            sel_q         <= sel_d;
            valid_q       <= valid_d;
            lane_q        <= lane_d;
            drop_sticky_q <= drop_sticky_d;
        end
    end

    assign score_updater_selector = sel_q;
    assign judge_valid            = valid_q;
    assign judge_lane             = lane_q;
    assign drop_sticky            = drop_sticky_q;
endmodule
